// File: rtl/fwd_hazard_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand-forwarding and load-use hazard unit for the EX stage. It keeps a
// short history of the destination writes that left EX (entry 0 = EX/MEM,
// entry 1 = MEM/WB, entry 2 = post-WB, ...). Each cycle it resolves NREAD
// source operands of the instruction in EX against that history and raises
// a stall for load-use hazards and for outstanding load data.
//
// Optional build macro:
//   FWD_PERF_CNT_EN - adds stall_cnt_o / fwd_cnt_o performance counters.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   ext_stall_i         stall from elsewhere; freezes the history shift
//   flush_i             kills the EX instruction (its write is not recorded)
//   ex_valid_i          instruction present in EX
//   ex_wen_i            EX instruction writes rd
//   ex_is_load_i        EX instruction is a load (data arrives later)
//   ex_rd_i             EX destination register
//   ex_result_i         ALU result of the EX instruction
//   mem_load_valid_i    load data for entry 0 returned this cycle
//   mem_load_data_i     returned load data
//   rs_i                source registers, port k at [k*AW +: AW]
//   rs_used_i           port k actually reads its rs
//   rf_data_i           register-file values, port k at [k*XLEN +: XLEN]
//   operand_o           resolved operands, port k at [k*XLEN +: XLEN]
//   fwd_sel_o           per-port select: 0 = register file, j+1 = entry j
//   stall_o             hazard stall request to the pipeline
//   stall_cnt_o         (FWD_PERF_CNT_EN) cycles with stall_o high
//   fwd_cnt_o           (FWD_PERF_CNT_EN) advancing cycles with a forward
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2,
  parameter int DEPTH = 3,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ext_stall_i,
  input  logic                   flush_i,
  input  logic                   ex_valid_i,
  input  logic                   ex_wen_i,
  input  logic                   ex_is_load_i,
  input  logic [AW-1:0]          ex_rd_i,
  input  logic [XLEN-1:0]        ex_result_i,
  input  logic                   mem_load_valid_i,
  input  logic [XLEN-1:0]        mem_load_data_i,
  input  logic [NREAD*AW-1:0]    rs_i,
  input  logic [NREAD-1:0]       rs_used_i,
  input  logic [NREAD*XLEN-1:0]  rf_data_i,
  output logic [NREAD*XLEN-1:0]  operand_o,
  output logic [NREAD*SW-1:0]    fwd_sel_o,
  output logic                   stall_o
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            fwd_cnt_o
`endif
);

  // History entries.
  logic            valid_q   [DEPTH];
  logic            valid_d   [DEPTH];
  logic [AW-1:0]   rd_q      [DEPTH];
  logic [AW-1:0]   rd_d      [DEPTH];
  logic [XLEN-1:0] data_q    [DEPTH];
  logic [XLEN-1:0] data_d    [DEPTH];
  logic            pending_q [DEPTH];
  logic            pending_d [DEPTH];

  // Per-port resolution results.
  logic [SW-1:0]   sel       [NREAD];
  logic [XLEN-1:0] opnd      [NREAD];
  logic [NREAD-1:0] port_pend;

  logic advance;
  logic fill;
  logic new_valid;

  // -------------------------------------------------------------------------
  // Operand resolution. Entries are scanned from oldest to youngest so the
  // last hit (the lowest index, i.e. the youngest write) wins.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    port_pend = '0;
    for (int k = 0; k < NREAD; k++) begin
      sel[k]  = '0;
      opnd[k] = rf_data_i[k*XLEN +: XLEN];
      // x0 is hard-wired zero: never forwarded, never stalls.
      if (rs_used_i[k] && (rs_i[k*AW +: AW] != '0)) begin
        for (int j = DEPTH - 1; j >= 0; j--) begin
          if (valid_q[j] && (rd_q[j] == rs_i[k*AW +: AW])) begin
            sel[k]       = SW'(j + 1);
            opnd[k]      = data_q[j];
            port_pend[k] = pending_q[j];
          end
        end
      end
    end
  end

  always_comb begin
    operand_o = '0;
    fwd_sel_o = '0;
    for (int k = 0; k < NREAD; k++) begin
      operand_o[k*XLEN +: XLEN] = opnd[k];
      fwd_sel_o[k*SW +: SW]     = sel[k];
    end
  end

  // -------------------------------------------------------------------------
  // Hazard detection. Load data is registered into the history and never
  // bypassed combinationally, so a dependent consumer stalls even in the
  // cycle the data returns.
  // -------------------------------------------------------------------------
  assign stall_o   = (pending_q[0] & ~mem_load_valid_i) | (|port_pend);
  assign advance   = ~stall_o & ~ext_stall_i;
  assign fill      = mem_load_valid_i & valid_q[0] & pending_q[0];
  assign new_valid = ex_valid_i & ex_wen_i & ~flush_i & (ex_rd_i != '0);

  // -------------------------------------------------------------------------
  // History next state.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      valid_d[j]   = valid_q[j];
      rd_d[j]      = rd_q[j];
      data_d[j]    = data_q[j];
      pending_d[j] = pending_q[j];
    end

    if (advance) begin
      for (int j = DEPTH - 1; j >= 1; j--) begin
        valid_d[j]   = valid_q[j-1];
        rd_d[j]      = rd_q[j-1];
        data_d[j]    = data_q[j-1];
        pending_d[j] = pending_q[j-1];
      end
      valid_d[0]   = new_valid;
      rd_d[0]      = ex_rd_i;
      data_d[0]    = ex_result_i;
      pending_d[0] = ex_is_load_i & new_valid;
      // The returning load has already moved down one slot.
      if (fill) begin
        data_d[1]    = mem_load_data_i;
        pending_d[1] = 1'b0;
      end
    end else if (fill) begin
      data_d[0]    = mem_load_data_i;
      pending_d[0] = 1'b0;
    end
  end

  // NOTE: the history is a handful of flops, not a RAM, so every entry is
  // cleared on reset; a stale valid bit would otherwise forward garbage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        valid_q[j]   <= 1'b0;
        rd_q[j]      <= '0;
        data_q[j]    <= '0;
        pending_q[j] <= 1'b0;
      end
    end else begin
      // NOTE: non-blocking assignments so every entry samples the pre-edge
      // value of its neighbour during the shift.
      for (int j = 0; j < DEPTH; j++) begin
        valid_q[j]   <= valid_d[j];
        rd_q[j]      <= rd_d[j];
        data_q[j]    <= data_d[j];
        pending_q[j] <= pending_d[j];
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  // -------------------------------------------------------------------------
  // Performance counters (wrap naturally at 2^32).
  // -------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q,   fwd_cnt_d;
  logic        any_fwd;

  always_comb begin
    any_fwd     = |fwd_sel_o;
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_o) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (advance && any_fwd) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
`timescale 1ns/1ps
// Self-checking bench for fwd_hazard_unit (default parameters: XLEN=32,
// AW=5, NREAD=2, DEPTH=3, SW=2). Expected outputs are queued when a cycle's
// stimulus is driven and popped and compared at the following falling edge.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_stall_i;
  logic        flush_i;
  logic        ex_valid_i;
  logic        ex_wen_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_i;
  logic [31:0] ex_result_i;
  logic        mem_load_valid_i;
  logic [31:0] mem_load_data_i;
  logic [9:0]  rs_i;
  logic [1:0]  rs_used_i;
  logic [63:0] rf_data_i;
  logic [63:0] operand_o;
  logic [3:0]  fwd_sel_o;
  logic        stall_o;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] fwd_cnt_o;
`endif

  fwd_hazard_unit dut (
    .clk              (clk),
    .rst              (rst),
    .ext_stall_i      (ext_stall_i),
    .flush_i          (flush_i),
    .ex_valid_i       (ex_valid_i),
    .ex_wen_i         (ex_wen_i),
    .ex_is_load_i     (ex_is_load_i),
    .ex_rd_i          (ex_rd_i),
    .ex_result_i      (ex_result_i),
    .mem_load_valid_i (mem_load_valid_i),
    .mem_load_data_i  (mem_load_data_i),
    .rs_i             (rs_i),
    .rs_used_i        (rs_used_i),
    .rf_data_i        (rf_data_i),
    .operand_o        (operand_o),
    .fwd_sel_o        (fwd_sel_o),
    .stall_o          (stall_o)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cnt_o      (stall_cnt_o),
    .fwd_cnt_o        (fwd_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  sel0;
    logic [31:0] op0;
    logic [1:0]  sel1;
    logic [31:0] op1;
    logic        stall;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Register-file contents seen by each port: tagged so they never collide
  // with any forwarded value.
  function automatic logic [31:0] rfv0(input logic [4:0] r);
    return 32'hA000_0000 | {27'b0, r};
  endfunction

  function automatic logic [31:0] rfv1(input logic [4:0] r);
    return 32'hB000_0000 | {27'b0, r};
  endfunction

  task automatic set_ex(input logic v, input logic wen, input logic ld,
                        input logic [4:0] rd, input logic [31:0] res);
    ex_valid_i   = v;
    ex_wen_i     = wen;
    ex_is_load_i = ld;
    ex_rd_i      = rd;
    ex_result_i  = res;
  endtask

  task automatic set_rs(input logic [4:0] r0, input logic [4:0] r1,
                        input logic [1:0] used);
    rs_i      = {r1, r0};
    rs_used_i = used;
    rf_data_i = {rfv1(r1), rfv0(r0)};
  endtask

  task automatic set_mem(input logic v, input logic [31:0] d);
    mem_load_valid_i = v;
    mem_load_data_i  = d;
  endtask

  // Queue the expectation for the cycle being driven, then compare it at the
  // falling edge and move to just after the next rising edge.
  task automatic step(input string name, input logic [1:0] s0,
                      input logic [31:0] o0, input logic [1:0] s1,
                      input logic [31:0] o1, input logic st);
    exp_t e;
    e.name = name; e.sel0 = s0; e.op0 = o0; e.sel1 = s1; e.op1 = o1;
    e.stall = st;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if (fwd_sel_o[1:0] !== e.sel0) begin
      errors++;
      $display("FAIL %s sel0: got %0d expected %0d", e.name, fwd_sel_o[1:0], e.sel0);
    end
    checks++;
    if (operand_o[31:0] !== e.op0) begin
      errors++;
      $display("FAIL %s op0: got %h expected %h", e.name, operand_o[31:0], e.op0);
    end
    checks++;
    if (fwd_sel_o[3:2] !== e.sel1) begin
      errors++;
      $display("FAIL %s sel1: got %0d expected %0d", e.name, fwd_sel_o[3:2], e.sel1);
    end
    checks++;
    if (operand_o[63:32] !== e.op1) begin
      errors++;
      $display("FAIL %s op1: got %h expected %h", e.name, operand_o[63:32], e.op1);
    end
    checks++;
    if (stall_o !== e.stall) begin
      errors++;
      $display("FAIL %s stall: got %b expected %b", e.name, stall_o, e.stall);
    end
    @(posedge clk);
    #1;
  endtask

  // Push DEPTH bubbles through so the history holds no valid entries.
  task automatic clear_history();
    flush_i = 1'b0; ext_stall_i = 1'b0;
    set_mem(1'b0, 32'h0);
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_rs(5'd0, 5'd0, 2'b00);
    for (int i = 0; i < 3; i++) step("clear", 2'd0, rfv0(0), 2'd0, rfv1(0), 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush_i = 1'b0; ext_stall_i = 1'b0;
    set_mem(1'b0, 32'h0);
    set_ex(1'b1, 1'b1, 1'b0, 5'd5, 32'h55);
    set_rs(5'd5, 5'd5, 2'b11);
    #2;
    checks++;
    if (fwd_sel_o !== 4'd0) begin
      errors++; $display("FAIL reset_sel: got %h expected 0", fwd_sel_o);
    end
    checks++;
    if (operand_o !== {rfv1(5), rfv0(5)}) begin
      errors++; $display("FAIL reset_op: got %h expected %h", operand_o, {rfv1(5), rfv0(5)});
    end
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", stall_o);
    end
`ifdef FWD_PERF_CNT_EN
    checks++;
    if (stall_cnt_o !== 32'd0 || fwd_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt_o, fwd_cnt_o);
    end
`endif
    // Held through a clock edge: the EX write to x5 must not be recorded.
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("reset_hist", 2'd0, rfv0(5), 2'd0, rfv1(5), 1'b0);
  endtask

  task automatic test_alu_chain();
    clear_history();
    set_ex(1'b1, 1'b1, 1'b0, 5'd5, 32'h11);
    set_rs(5'd1, 5'd2, 2'b11);
    step("alu_prod", 2'd0, rfv0(1), 2'd0, rfv1(2), 1'b0);
    set_ex(1'b1, 1'b1, 1'b0, 5'd10, 32'h22);
    set_rs(5'd5, 5'd3, 2'b11);
    step("alu_cons", 2'd1, 32'h11, 2'd0, rfv1(3), 1'b0);
    // Port 0 not used: must take the register file even though x5 matches.
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_rs(5'd5, 5'd10, 2'b10);
    step("alu_unused", 2'd0, rfv0(5), 2'd1, 32'h22, 1'b0);
  endtask

  task automatic test_distance();
    clear_history();
    set_ex(1'b1, 1'b1, 1'b0, 5'd6, 32'hAA);
    set_rs(5'd0, 5'd0, 2'b00);
    step("dist_prod", 2'd0, rfv0(0), 2'd0, rfv1(0), 1'b0);
    set_ex(1'b1, 1'b1, 1'b0, 5'd12, 32'h5);
    step("dist_unrel", 2'd0, rfv0(0), 2'd0, rfv1(0), 1'b0);
    set_ex(1'b1, 1'b1, 1'b0, 5'd13, 32'h6);
    set_rs(5'd6, 5'd12, 2'b11);
    step("dist2", 2'd2, 32'hAA, 2'd1, 32'h5, 1'b0);
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_rs(5'd6, 5'd13, 2'b11);
    step("dist3", 2'd3, 32'hAA, 2'd1, 32'h6, 1'b0);
    set_rs(5'd6, 5'd6, 2'b11);
    step("dist4", 2'd0, rfv0(6), 2'd0, rfv1(6), 1'b0);
  endtask

  task automatic test_load_use();
    clear_history();
    set_ex(1'b1, 1'b1, 1'b1, 5'd7, 32'h1234);
    set_rs(5'd0, 5'd0, 2'b00);
    step("lu_load", 2'd0, rfv0(0), 2'd0, rfv1(0), 1'b0);
    // Data returns this cycle but is not bypassed: one stall cycle.
    set_ex(1'b1, 1'b1, 1'b0, 5'd14, 32'h77);
    set_rs(5'd7, 5'd7, 2'b11);
    set_mem(1'b1, 32'hDEAD);
    step("lu_stall", 2'd1, 32'h1234, 2'd1, 32'h1234, 1'b1);
    set_mem(1'b0, 32'h0);
    step("lu_fwd", 2'd1, 32'hDEAD, 2'd1, 32'hDEAD, 1'b0);
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_rs(5'd7, 5'd14, 2'b11);
    step("lu_after", 2'd2, 32'hDEAD, 2'd1, 32'h77, 1'b0);
  endtask

  task automatic test_mem_wait();
    clear_history();
    set_ex(1'b1, 1'b1, 1'b1, 5'd15, 32'h40);
    set_rs(5'd0, 5'd0, 2'b00);
    step("mw_load", 2'd0, rfv0(0), 2'd0, rfv1(0), 1'b0);
    set_ex(1'b1, 1'b1, 1'b0, 5'd16, 32'h99);
    set_rs(5'd1, 5'd2, 2'b11);
    for (int i = 0; i < 3; i++) step("mw_wait", 2'd0, rfv0(1), 2'd0, rfv1(2), 1'b1);
    set_mem(1'b1, 32'hBEEF);
    step("mw_ret", 2'd0, rfv0(1), 2'd0, rfv1(2), 1'b0);
    set_mem(1'b0, 32'h0);
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_rs(5'd15, 5'd16, 2'b11);
    step("mw_after", 2'd2, 32'hBEEF, 2'd1, 32'h99, 1'b0);
  endtask

  task automatic test_ext_stall();
    clear_history();
    set_ex(1'b1, 1'b1, 1'b1, 5'd17, 32'h70);
    set_rs(5'd0, 5'd0, 2'b00);
    step("es_load", 2'd0, rfv0(0), 2'd0, rfv1(0), 1'b0);
    ext_stall_i = 1'b1;
    set_ex(1'b1, 1'b1, 1'b0, 5'd20, 32'h5);
    set_rs(5'd1, 5'd17, 2'b11);
    step("es_wait", 2'd0, rfv0(1), 2'd1, 32'h70, 1'b1);
    // Both stalls active: no shift, fill still lands in entry 0.
    set_mem(1'b1, 32'hCAFE);
    step("es_fill", 2'd0, rfv0(1), 2'd1, 32'h70, 1'b1);
    set_mem(1'b0, 32'h0);
    step("es_hold", 2'd0, rfv0(1), 2'd1, 32'hCAFE, 1'b0);
    ext_stall_i = 1'b0;
    step("es_go", 2'd0, rfv0(1), 2'd1, 32'hCAFE, 1'b0);
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_rs(5'd17, 5'd20, 2'b11);
    step("es_after", 2'd2, 32'hCAFE, 2'd1, 32'h5, 1'b0);
  endtask

  task automatic test_priority_x0_flush();
    clear_history();
    set_ex(1'b1, 1'b1, 1'b0, 5'd8, 32'h2);
    step("pr_old", 2'd0, rfv0(0), 2'd0, rfv1(0), 1'b0);
    set_ex(1'b1, 1'b1, 1'b0, 5'd8, 32'h1);
    step("pr_new", 2'd0, rfv0(0), 2'd0, rfv1(0), 1'b0);
    set_ex(1'b1, 1'b1, 1'b0, 5'd0, 32'h3);
    set_rs(5'd8, 5'd8, 2'b11);
    step("pr_pick", 2'd1, 32'h1, 2'd1, 32'h1, 1'b0);
    // x0 write above must not be recorded; x0 read must use the RF.
    set_ex(1'b1, 1'b1, 1'b0, 5'd9, 32'h99);
    flush_i = 1'b1;
    set_rs(5'd0, 5'd0, 2'b11);
    step("pr_x0", 2'd0, rfv0(0), 2'd0, rfv1(0), 1'b0);
    flush_i = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_rs(5'd9, 5'd8, 2'b11);
    step("pr_flush", 2'd0, rfv0(9), 2'd3, 32'h1, 1'b0);
  endtask

  task automatic test_reset_mid_stall();
    clear_history();
    set_ex(1'b1, 1'b1, 1'b1, 5'd18, 32'h50);
    step("rms_load", 2'd0, rfv0(0), 2'd0, rfv1(0), 1'b0);
    set_ex(1'b1, 1'b1, 1'b0, 5'd19, 32'h3);
    set_rs(5'd18, 5'd18, 2'b01);
    step("rms_wait", 2'd1, 32'h50, 2'd0, rfv1(18), 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL rms_stall: got %b expected 0", stall_o);
    end
    checks++;
    if (fwd_sel_o !== 4'd0) begin
      errors++; $display("FAIL rms_sel: got %h expected 0", fwd_sel_o);
    end
    checks++;
    if (operand_o[31:0] !== rfv0(18)) begin
      errors++; $display("FAIL rms_op: got %h expected %h", operand_o[31:0], rfv0(18));
    end
`ifdef FWD_PERF_CNT_EN
    checks++;
    if (stall_cnt_o !== 32'd0) begin
      errors++; $display("FAIL rms_cnt: got %0d expected 0", stall_cnt_o);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_rs(5'd18, 5'd18, 2'b11);
    step("rms_after", 2'd0, rfv0(18), 2'd0, rfv1(18), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_chain();
    test_distance();
    test_load_use();
    test_mem_wait();
    test_ext_stall();
    test_priority_x0_flush();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
